// File: rtl/sram_arbiter.sv
// Two-master arbiter that routes instruction fetches and load/stores onto one SRAM-like channel.
// It allows one outstanding transaction and uses a bounded starvation counter that makes fetch win after too many data grants.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] starve_r;
    logic          owner_data_r;
    logic          mem_wr_r;
    logic [3:0]    mem_wstrb_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          grant_inst_s;
    logic          grant_data_s;

    // Grant decision: data wins ties unless fetch has been starved up to the limit
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (state_r == IDLE && !reset) begin
            if (inst_req && (!data_req || starve_r == LIMIT)) begin
                grant_inst_s = 1'b1;
            end else if (data_req) begin
                grant_data_s = 1'b1;
            end else begin
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; acknowledges outside their own phase are ignored
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = (grant_inst_s || grant_data_s) ? REQ : IDLE;
            REQ:     state_s = mem_addr_ok ? RESP : REQ;
            RESP:    state_s = mem_data_ok ? IDLE : RESP;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: grants and responses are combinational pulses
    always_comb begin
        mem_req      = (state_r == REQ);
        inst_addr_ok = grant_inst_s;
        data_addr_ok = grant_data_s;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (state_r == RESP && mem_data_ok && !reset) begin
            inst_data_ok = !owner_data_r;
            data_data_ok = owner_data_r;
        end else begin
            inst_data_ok = 1'b0;
        end
    end

    // Latch the winner's request fields so they stay stable through REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_data_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_wstrb_r  <= 4'h0;
            mem_addr_r   <= 32'h0;
            mem_wdata_r  <= 32'h0;
        end else if (grant_inst_s) begin
            owner_data_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_wstrb_r  <= 4'h0;
            mem_addr_r   <= inst_addr;
            mem_wdata_r  <= 32'h0;
        end else if (grant_data_s) begin
            owner_data_r <= 1'b1;
            mem_wr_r     <= data_wr;
            mem_wstrb_r  <= data_wstrb;
            mem_addr_r   <= data_addr;
            mem_wdata_r  <= data_wdata;
        end else begin
            owner_data_r <= owner_data_r;
        end
    end

    // Starvation counter: counts data grants taken over a waiting fetch, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_r <= '0;
        end else if (grant_inst_s) begin
            starve_r <= '0;
        end else if (grant_data_s && inst_req) begin
            starve_r <= (starve_r == LIMIT) ? starve_r : starve_r + 1'b1;
        end else if (state_r == IDLE && !inst_req) begin
            starve_r <= '0;
        end else begin
            starve_r <= starve_r;
        end
    end

    assign mem_wr     = mem_wr_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: load, store with a stalled memory, arbitration order, stray acknowledges, and reset mid-response.
// Inputs change 1 time unit after a rising edge, and outputs are checked 2 time units later.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // One transaction with both masters requesting and memory answering each phase at once
    task automatic txn(input logic exp_inst, input logic [31:0] rd);
        settle();
        chk("grant_inst", inst_addr_ok, exp_inst);
        chk("grant_data", data_addr_ok, !exp_inst);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("txn_mem_req", mem_req, 1'b1);
        chk("txn_mem_addr", mem_addr, exp_inst ? 32'hBFC0_0000 : 32'h0000_3000);
        chk("txn_mem_wr", mem_wr, !exp_inst);
        chk("txn_mem_wdata", mem_wdata, exp_inst ? 32'h0 : 32'hAAAA_5555);
        chk("txn_no_grant", inst_addr_ok | data_addr_ok, 1'b0);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        settle();
        chk("txn_inst_data_ok", inst_data_ok, exp_inst);
        chk("txn_data_data_ok", data_data_ok, !exp_inst);
        chk("txn_rdata", exp_inst ? inst_rdata : data_rdata, rd);
        chk("txn_no_grant_resp", inst_addr_ok | data_addr_ok, 1'b0);
        tick();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h1000; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        settle();
        chk("rst_no_grant", data_addr_ok, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);

        // Single load
        tick();
        reset = 1'b0;
        settle();
        chk("load_T0_addr_ok", data_addr_ok, 1'b1);
        chk("load_T0_inst_ok", inst_addr_ok, 1'b0);
        chk("load_T0_mem_req", mem_req, 1'b0);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b1;
        settle();
        chk("load_T1_mem_req", mem_req, 1'b1);
        chk("load_T1_mem_addr", mem_addr, 32'h1000);
        chk("load_T1_mem_wr", mem_wr, 1'b0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("load_T2_mem_req", mem_req, 1'b0);
        chk("load_T2_data_ok", data_data_ok, 1'b1);
        chk("load_T2_rdata", data_rdata, 32'hDEAD_BEEF);
        chk("load_T2_inst_ok", inst_data_ok, 1'b0);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("load_T3_data_ok", data_data_ok, 1'b0);

        // Store held while memory stalls, with stray data_ok during REQ
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hC;
        data_wdata = 32'h1234_5678; data_addr = 32'h2004;
        settle();
        chk("st_addr_ok", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h3;
        data_wdata = 32'hFFFF_0000; data_addr = 32'h9999;
        mem_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_hold_req", mem_req, 1'b1);
            chk("st_hold_wr", mem_wr, 1'b1);
            chk("st_hold_wstrb", mem_wstrb, 4'hC);
            chk("st_hold_addr", mem_addr, 32'h2004);
            chk("st_hold_wdata", mem_wdata, 32'h1234_5678);
            chk("st_stray_req", data_data_ok, 1'b0);
            tick();
        end
        mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
        settle();
        chk("st_req_accept", mem_req, 1'b1);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("st_done", data_data_ok, 1'b1);
        tick();
        settle();
        chk("st_stray_idle", data_data_ok | inst_data_ok, 1'b0);
        chk("st_idle_mem_req", mem_req, 1'b0);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("st_idle_stays", mem_req, 1'b0);

        // Arbitration with both masters requesting continuously
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
        data_addr = 32'h3000; data_wdata = 32'hAAAA_5555;
        txn(1'b0, 32'h0000_0001);
        txn(1'b0, 32'h0000_0002);
        txn(1'b1, 32'h0000_0003);
        txn(1'b0, 32'h0000_0004);
        txn(1'b0, 32'h0000_0005);
        txn(1'b1, 32'h0000_0006);

        // Reset while awaiting a response, with the counter at its limit
        txn(1'b0, 32'h0000_0007);
        settle();
        chk("rr_grant", data_addr_ok, 1'b1);
        tick();
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        settle();
        chk("rr_in_resp", data_data_ok | mem_req, 1'b0);
        tick();
        reset = 1'b1;
        settle();
        chk("rr_rst_no_grant", inst_addr_ok | data_addr_ok, 1'b0);
        tick();
        reset = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("rr_abandoned", data_data_ok | inst_data_ok, 1'b0);
        chk("rr_mem_req", mem_req, 1'b0);
        chk("rr_cnt_clear_data", data_addr_ok, 1'b1);
        chk("rr_cnt_clear_inst", inst_addr_ok, 1'b0);
        tick();
        mem_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        settle();
        chk("rr_req_phase", mem_req, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2: consecutive data grants allowed while inst_req is pending before inst is forced to win.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 inst_req  in  1  fetch read request.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted (grant).
REQ-007 inst_data_ok  out  1  fetch read data valid.
REQ-008 inst_rdata  out  32  fetch read data.
REQ-009 data_req  in  1  load/store request from EX.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_wstrb  in  4  store byte enables.
REQ-012 data_addr  in  32  load/store address (ALU result).
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  load/store accepted (grant).
REQ-015 data_data_ok  out  1  load data valid or store complete.
REQ-016 data_rdata  out  32  load data.
REQ-017 mem_req, mem_wr, mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  shared SRAM-like request channel.
REQ-018 mem_addr_ok  in  1  memory accepted the request.
REQ-019 mem_data_ok  in  1  memory response valid.
REQ-020 mem_rdata  in  32  memory read data.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, RESP; at most one transaction outstanding.
REQ-022 IDLE: if any request is pending, the arbiter SHALL grant one, pulse the winner's *_addr_ok combinationally that cycle, latch the winner's fields and the owner id, and enter REQ next cycle.
REQ-023 Priority: data SHALL win when both request, unless the starvation counter equals STARVE_LIMIT, in which case inst SHALL win.
REQ-024 Starvation counter SHALL increment on a data grant while inst_req=1, clear on any inst grant, clear when inst_req=0 in IDLE, and saturate at STARVE_LIMIT.
REQ-025 Inst grants SHALL latch mem_wr=0, mem_wstrb=0, mem_wdata=0.
REQ-026 REQ: mem_req SHALL be 1 with latched fields held stable; on mem_addr_ok=1 go to RESP next cycle.
REQ-027 RESP: mem_req SHALL be 0; on mem_data_ok=1 the owner's *_data_ok SHALL pulse combinationally that cycle with *_rdata=mem_rdata, and the FSM SHALL return to IDLE.
REQ-028 mem_data_ok outside RESP and mem_addr_ok outside REQ SHALL be ignored.
REQ-029 Non-owner *_data_ok and all *_addr_ok outside IDLE SHALL be 0; both *_rdata SHALL carry mem_rdata at all times.
REQ-030 Minimum latency SHALL be 3 cycles from grant to *_data_ok (memory answering each phase immediately); no new grant occurs in the cycle data_ok pulses.
REQ-031 Stores SHALL complete with data_data_ok exactly like loads; data_rdata is don't-care then.

Reset
REQ-032 reset=1 SHALL force IDLE, counter=0, latched fields=0, mem_req=0 and every *_addr_ok/*_data_ok=0 next cycle, including mid-REQ or mid-RESP; a pending response is abandoned.
REQ-033 After reset, no grant SHALL occur in a cycle where reset=1.

Verification
REQ-034 Single load: data_req=1, addr=0x1000, memory acks in 1 cycle each, rdata=0xDEADBEEF -> data_addr_ok at T0, mem_req at T1, data_data_ok with 0xDEADBEEF at T2.
REQ-035 Simultaneous: inst_req=data_req=1 continuously, STARVE_LIMIT=2 -> grant order data, data, inst, data, data, inst.
REQ-036 Store: data_wr=1, wstrb=0xC, wdata=0x12345678, addr=0x2004 -> mem_wr=1, mem_wstrb=0xC, mem_addr=0x2004 held while mem_addr_ok=0 for 3 cycles; data_data_ok pulses once.
REQ-037 Stray response: mem_data_ok=1 in IDLE and REQ -> no *_data_ok pulse, state unchanged.
REQ-038 Reset in RESP: assert reset one cycle while awaiting mem_data_ok -> IDLE next cycle, counter 0, later mem_data_ok produces no data_ok.
